bus_line_xfer: RTL



---
 rtl/bus_line_xfer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_line_xfer.sv
// -----------------------------------------------------------------------------
// bus_line_xfer
//
// Cache-line transfer engine between the core-side memory stages and the
// shared system bus. One request moves a whole line of BEATS beats:
//   - line read  (fill):      header with READ_TAG, then BEATS tagged responses
//   - line write (writeback): header with WRITE_TAG, then BEATS request beats
// The bus is acquired through the arbiter first. Completion is signalled by a
// one-cycle done pulse, with err=1 when a read gave up after TIMEOUT idle
// cycles.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start, write, addr,     request (sampled only while idle=1)
//   wr_line
//   idle, done, err         engine status / completion
//   rd_line                 captured read line (beat i at [i*W +: W])
//   abtr_reqcyc/abtr_grant  arbiter handshake
//   bus_busy                this engine owns the bus
//   main_bus_req*           request channel (header / write beats)
//   main_bus_resp*          response channel, acknowledged by main_bus_respack
// -----------------------------------------------------------------------------
module bus_line_xfer #(
    parameter int                       BUS_DATA_WIDTH = 64,
    parameter int                       BEATS          = 8,
    parameter int                       BUS_TAG_WIDTH  = 13,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h1100,
    parameter logic [BUS_TAG_WIDTH-1:0] WRITE_TAG      = 13'h0100,
    parameter int                       TIMEOUT        = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              write,
    input  logic [BUS_DATA_WIDTH-1:0]         addr,
    input  logic [BUS_DATA_WIDTH*BEATS-1:0]   wr_line,
    output logic                              idle,
    output logic                              done,
    output logic                              err,
    output logic [BUS_DATA_WIDTH*BEATS-1:0]   rd_line,
    output logic                              abtr_reqcyc,
    input  logic                              abtr_grant,
    output logic                              bus_busy,
    output logic                              main_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]         main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]          main_bus_reqtag,
    input  logic                              main_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]         main_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]          main_bus_resptag,
    output logic                              main_bus_respack
);

    localparam int W        = BUS_DATA_WIDTH;
    localparam int LINE_W   = BUS_DATA_WIDTH * BEATS;
    localparam int LINE_OFF = $clog2(BEATS * BUS_DATA_WIDTH / 8);
    localparam int BEAT_W   = $clog2(BEATS);
    // Counter only has to reach TIMEOUT-1; the abort fires on the cycle after.
    localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TMO_EN   = (TIMEOUT > 0);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_HDR   = 3'd2,
        ST_WDATA = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t              state_q;
    logic                write_q;
    logic [W-1:0]        addr_q;
    logic [LINE_W-1:0]   wr_line_q;
    logic [LINE_W-1:0]   rd_line_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                idle_q;
    logic                done_q;
    logic                err_q;
    logic                abtr_reqcyc_q;
    logic                bus_busy_q;
    logic                reqcyc_q;
    logic [W-1:0]        req_q;
    logic [BUS_TAG_WIDTH-1:0] reqtag_q;
    logic                resp_match_s;

    // Select beat idx out of a packed line.
    function automatic logic [W-1:0] line_beat(input logic [LINE_W-1:0] line,
                                               input logic [BEAT_W-1:0] idx);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (idx == BEAT_W'(i)) begin
                b = line[i*W +: W];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // A response beat is taken only while waiting for read data and only with
    // the read tag; the acknowledge has to answer in the same cycle.
    assign resp_match_s = ((state_q == ST_WAIT) || (state_q == ST_RESP)) &&
                          main_bus_respcyc && (main_bus_resptag == READ_TAG);

    // Transfer FSM with registered outputs, updated on each transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wr_line_q     <= '0;
            rd_line_q     <= '0;
            beat_q        <= '0;
            tmo_q         <= '0;
            idle_q        <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            abtr_reqcyc_q <= 1'b0;
            bus_busy_q    <= 1'b0;
            reqcyc_q      <= 1'b0;
            req_q         <= '0;
            reqtag_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        write_q       <= write;
                        addr_q        <= {addr[W-1:LINE_OFF], {LINE_OFF{1'b0}}};
                        wr_line_q     <= wr_line;
                        idle_q        <= 1'b0;
                        abtr_reqcyc_q <= 1'b1;
                        state_q       <= ST_ARB;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ARB: begin
                    if (abtr_grant) begin
                        abtr_reqcyc_q <= 1'b0;
                        bus_busy_q    <= 1'b1;
                        reqcyc_q      <= 1'b1;
                        req_q         <= addr_q;
                        reqtag_q      <= write_q ? WRITE_TAG : READ_TAG;
                        state_q       <= ST_HDR;
                    end else begin
                        state_q <= ST_ARB;
                    end
                end
                ST_HDR: begin
                    beat_q <= '0;
                    tmo_q  <= '0;
                    if (write_q) begin
                        req_q    <= line_beat(wr_line_q, '0);
                        reqtag_q <= WRITE_TAG;
                        state_q  <= ST_WDATA;
                    end else begin
                        reqcyc_q <= 1'b0;
                        req_q    <= '0;
                        reqtag_q <= '0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WDATA: begin
                    if (beat_q == LAST_BEAT) begin
                        reqcyc_q   <= 1'b0;
                        req_q      <= '0;
                        reqtag_q   <= '0;
                        bus_busy_q <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b0;
                        state_q    <= ST_DONE;
                    end else begin
                        beat_q <= beat_q + BEAT_ONE;
                        req_q  <= line_beat(wr_line_q, beat_q + BEAT_ONE);
                    end
                end
                ST_WAIT, ST_RESP: begin
                    if (resp_match_s) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_q == BEAT_W'(i)) begin
                                rd_line_q[i*W +: W] <= main_bus_resp;
                            end else begin
                                rd_line_q[i*W +: W] <= rd_line_q[i*W +: W];
                            end
                        end
                        tmo_q <= '0;
                        if (beat_q == LAST_BEAT) begin
                            bus_busy_q <= 1'b0;
                            done_q     <= 1'b1;
                            err_q      <= 1'b0;
                            state_q    <= ST_DONE;
                        end else begin
                            beat_q  <= beat_q + BEAT_ONE;
                            state_q <= ST_RESP;
                        end
                    end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                        // Timeout abort: rd_line keeps whatever arrived so far.
                        bus_busy_q <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (TMO_EN) begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end else begin
                        tmo_q <= tmo_q;
                    end
                end
                ST_DONE: begin
                    // start is ignored here; it is only sampled back in IDLE.
                    err_q   <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    idle_q        <= 1'b1;
                    err_q         <= 1'b0;
                    abtr_reqcyc_q <= 1'b0;
                    bus_busy_q    <= 1'b0;
                    reqcyc_q      <= 1'b0;
                    req_q         <= '0;
                    reqtag_q      <= '0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign idle             = idle_q;
    assign done             = done_q;
    assign err              = err_q;
    assign rd_line          = rd_line_q;
    assign abtr_reqcyc      = abtr_reqcyc_q;
    assign bus_busy         = bus_busy_q;
    assign main_bus_reqcyc  = reqcyc_q;
    assign main_bus_req     = req_q;
    assign main_bus_reqtag  = reqtag_q;
    assign main_bus_respack = resp_match_s;

endmodule
